// File: rtl/sudoku_scheduler_pkg.sv
// Shared types and widths for the sudoku engine scheduler.
// Holds the FSM states, status codes, grid write widths and the pass-count helper.
package sudoku_scheduler_pkg;

    localparam int CELL_W = 7;
    localparam int MASK_W = 9;
    localparam int PASS_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        STAT_NONE    = 3'd0,
        STAT_SOLVED  = 3'd1,
        STAT_STUCK   = 3'd2,
        STAT_INVALID = 3'd3,
        STAT_LIMIT   = 3'd4,
        STAT_TIMEOUT = 3'd5
    } status_t;

    // The pass counter sticks at all-ones instead of wrapping.
    function automatic logic [PASS_W-1:0] sat_inc(input logic [PASS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sudoku_scheduler_wr_mux.sv
// Grid write-port selector: forwards only the active engine's request.
// Purely combinational; every other engine's request is dropped.
module sched_wr_mux
    import sudoku_scheduler_pkg::*;
#(
    parameter int NUM_ENG = 3,
    parameter int IDX_W   = 2
) (
    input  logic                      i_en,
    input  logic [IDX_W-1:0]          i_sel,
    input  logic [NUM_ENG-1:0]        i_wr_en,
    input  logic [CELL_W*NUM_ENG-1:0] i_wr_cell,
    input  logic [MASK_W*NUM_ENG-1:0] i_wr_mask,
    output logic                      o_wr_en,
    output logic [CELL_W-1:0]         o_wr_cell,
    output logic [MASK_W-1:0]         o_wr_mask
);

    logic [NUM_ENG-1:0] w_hit;
    logic [CELL_W-1:0]  w_cell_term [NUM_ENG];
    logic [MASK_W-1:0]  w_mask_term [NUM_ENG];

    generate
        for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_port
            assign w_hit[gi]       = i_en && (i_sel == IDX_W'(gi));
            assign w_cell_term[gi] = w_hit[gi] ? i_wr_cell[gi*CELL_W +: CELL_W] : '0;
            assign w_mask_term[gi] = w_hit[gi] ? i_wr_mask[gi*MASK_W +: MASK_W] : '0;
        end
    endgenerate

    // At most one w_hit bit is set, so an OR-reduction acts as the mux.
    always_comb begin
        o_wr_cell = '0;
        o_wr_mask = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            o_wr_cell = o_wr_cell | w_cell_term[i];
            o_wr_mask = o_wr_mask | w_mask_term[i];
        end
    end

    assign o_wr_en = |(w_hit & i_wr_en);

endmodule

// File: rtl/sudoku_scheduler.sv
// Round-robin pass scheduler for candidate-elimination engines sharing one grid.
// Runs engines in order each pass, then checks the grid for a verdict.
module sudoku_scheduler
    import sudoku_scheduler_pkg::*;
#(
    parameter int NUM_ENG     = 3,
    parameter int MAX_PASS    = 64,
    parameter int ENG_TIMEOUT = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_load,
    input  logic                      i_load_done,
    output logic [NUM_ENG-1:0]        o_eng_start,
    input  logic [NUM_ENG-1:0]        i_eng_done,
    input  logic [NUM_ENG-1:0]        i_eng_changed,
    input  logic [NUM_ENG-1:0]        i_eng_wr_en,
    input  logic [CELL_W*NUM_ENG-1:0] i_eng_wr_cell,
    input  logic [MASK_W*NUM_ENG-1:0] i_eng_wr_mask,
    output logic                      o_grid_wr_en,
    output logic [CELL_W-1:0]         o_grid_wr_cell,
    output logic [MASK_W-1:0]         o_grid_wr_mask,
    input  logic                      i_grid_solved,
    input  logic                      i_grid_invalid,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [2:0]                o_status,
    output logic [PASS_W-1:0]         o_pass_cnt
);

    localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int TMO_W = $clog2(ENG_TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ENG - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(MAX_PASS - 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(ENG_TIMEOUT);

    state_t             r_state;
    state_t             w_state_next;
    status_t            r_status;
    status_t            w_status_next;
    logic [IDX_W-1:0]   r_idx;
    logic [PASS_W-1:0]  r_pass_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_progress;
    logic               r_first;
    logic               r_armed;

    logic               w_in_run;
    logic               w_act_done;
    logic               w_act_changed;
    logic               w_tmo;
    logic               w_start_ok;
    logic               w_launch;

    assign w_in_run      = (r_state == ST_RUN);
    assign w_act_done    = i_eng_done[r_idx];
    assign w_act_changed = i_eng_changed[r_idx];
    assign w_tmo         = w_in_run && (r_tmo_cnt == TMO_LIMIT);
    // r_armed keeps a start held through reset from launching in the first free cycle.
    assign w_start_ok    = r_armed && i_start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    // A new engine slot begins whenever RUN is (re)entered or the active engine hands over.
    assign w_launch      = (w_state_next == ST_RUN) && ((r_state != ST_RUN) || w_act_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_status <= STAT_NONE;
        end else begin
            r_state  <= w_state_next;
            r_status <= w_status_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_load_done) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A finishing engine wins over a timeout landing in the same cycle.
                if (w_act_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_next = ST_CHECK;
                    end
                end else if (w_tmo) begin
                    w_state_next  = ST_FIN;
                    w_status_next = STAT_TIMEOUT;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_FIN;
                if (i_grid_invalid) begin
                    w_status_next = STAT_INVALID;
                end else if (i_grid_solved) begin
                    w_status_next = STAT_SOLVED;
                end else if (!r_progress) begin
                    w_status_next = STAT_STUCK;
                end else if (r_pass_cnt == LAST_PASS) begin
                    w_status_next = STAT_LIMIT;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_FIN: begin
                if (w_start_ok) begin
                    w_state_next  = ST_LOAD;
                    w_status_next = STAT_NONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_tmo_cnt  <= '0;
            r_progress <= 1'b0;
            r_first    <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_first <= w_launch;
            if (w_launch) begin
                r_tmo_cnt <= '0;
            end else if (w_in_run && !w_tmo) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            case (r_state)
                ST_LOAD: begin
                    if (i_load_done) begin
                        r_idx      <= '0;
                        r_pass_cnt <= '0;
                        r_progress <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_act_changed) begin
                        r_progress <= 1'b1;
                    end
                    if (w_act_done && (r_idx != LAST_IDX)) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_state_next == ST_RUN) begin
                        r_pass_cnt <= sat_inc(r_pass_cnt);
                        r_progress <= 1'b0;
                        r_idx      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_load      = w_start_ok;
        o_busy      = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_CHECK);
        o_done      = (r_state == ST_FIN);
        o_status    = r_status;
        o_pass_cnt  = r_pass_cnt;
        o_eng_start = '0;
        if (w_in_run && r_first) begin
            o_eng_start[r_idx] = 1'b1;
        end
    end

    sched_wr_mux #(
        .NUM_ENG (NUM_ENG),
        .IDX_W   (IDX_W)
    ) u_wr_mux (
        .i_en      (w_in_run),
        .i_sel     (r_idx),
        .i_wr_en   (i_eng_wr_en),
        .i_wr_cell (i_eng_wr_cell),
        .i_wr_mask (i_eng_wr_mask),
        .o_wr_en   (o_grid_wr_en),
        .o_wr_cell (o_grid_wr_cell),
        .o_wr_mask (o_grid_wr_mask)
    );

endmodule
